// File: rtl/coeff_mult_pkg.sv
// Shared definitions for the twiddle-coefficient path: default widths,
// the clog2 helper, the round constant and the {re, im} half-slice macros
// used by both the coefficient generator and the coefficient multiplier.
`ifndef COEFF_MULT_PKG_SV
`define COEFF_MULT_PKG_SV

// Upper half of a packed {re, im} word whose components are W bits wide
`define CM_RE(v, W) v[2*(W)-1:(W)]
// Lower half of a packed {re, im} word whose components are W bits wide
`define CM_IM(v, W) v[(W)-1:0]

package coeff_mult_pkg;

  localparam int NBITS_DEF = 8;
  localparam int DBITS_DEF = 12;
  localparam int N_DEF     = 8;

  // Alignment tracker: the first valid sample after reset may carry a
  // frame marker at any counter value without being flagged.
  typedef enum logic {
    SYNC_FIRST,
    SYNC_TRACK
  } syncState_e;

  // Ceiling log2 with a floor of 1 so a one-entry frame still has an index bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // Half an LSB of the Q1.(nbits-1) product scale, for round-half-up
  function automatic int roundConst(input int nbits);
    return 1 << (nbits - 2);
  endfunction

endpackage

`endif

// File: rtl/coeff_mult_round_sat.sv
// Round-half-up, arithmetic shift right and saturate a signed value down
// to a narrower signed output. Purely combinational; the caller registers.
module round_sat #(
  parameter int IN_W  = 21,
  parameter int SHIFT = 7,
  parameter int OUT_W = 12,
  parameter int RND   = 64
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val
);

  // One guard bit keeps the rounding add from wrapping at the positive end
  localparam int SW = IN_W + 1;

  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [SW-1:0] RNDV = SW'(RND);

  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_shift;

  // Add the half-LSB, floor-shift, then clamp into the output range
  always_comb begin
    w_sum   = $signed({i_val[IN_W-1], i_val}) + RNDV;
    w_shift = w_sum >>> SHIFT;
    o_val   = w_shift[OUT_W-1:0];
    if (w_shift > MAXV) begin
      o_val = MAXV[OUT_W-1:0];
    end else if (w_shift < MINV) begin
      o_val = MINV[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/coeff_mult.sv
// Coefficient multiplier: complex product of each data sample with its
// twiddle coefficient, frame-index tagging with a sticky alignment flag,
// and rounding/saturation back to data width. Three register stages.
module coeff_mult
  import coeff_mult_pkg::*;
#(
  parameter  int NBITS = NBITS_DEF,
  parameter  int DBITS = DBITS_DEF,
  parameter  int N     = N_DEF,
  localparam int IW    = clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [2*NBITS-1:0] i_coeff,
  input  logic [2*DBITS-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_sof,
  output logic [2*DBITS-1:0] o_data,
  output logic               o_valid,
  output logic               o_sof,
  output logic [IW-1:0]      o_index,
  output logic               o_syncErr
);

  localparam int PW = DBITS + NBITS;
  localparam int SW = PW + 1;

  syncState_e r_state;
  syncState_e w_stateNext;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idxNext;
  logic [IW-1:0] w_tag;
  logic          w_misalign;

  logic                    r_s1Valid;
  logic                    r_s1Sof;
  logic [IW-1:0]           r_s1Index;
  logic signed [DBITS-1:0] r_s1Dr;
  logic signed [DBITS-1:0] r_s1Di;
  logic signed [NBITS-1:0] r_s1Cr;
  logic signed [NBITS-1:0] r_s1Ci;

  logic                 r_s2Valid;
  logic                 r_s2Sof;
  logic [IW-1:0]        r_s2Index;
  logic signed [PW-1:0] r_s2Prr;
  logic signed [PW-1:0] r_s2Pii;
  logic signed [PW-1:0] r_s2Pri;
  logic signed [PW-1:0] r_s2Pir;

  logic signed [SW-1:0]    w_sumRe;
  logic signed [SW-1:0]    w_sumIm;
  logic signed [DBITS-1:0] w_outRe;
  logic signed [DBITS-1:0] w_outIm;

  // Index assignment and misalignment detection for the incoming sample
  always_comb begin
    w_tag       = r_idx;
    w_idxNext   = r_idx;
    w_stateNext = r_state;
    w_misalign  = 1'b0;
    if (i_valid) begin
      w_tag       = i_sof ? '0 : r_idx;
      w_idxNext   = (w_tag == IW'(N - 1)) ? '0 : w_tag + IW'(1);
      w_stateNext = SYNC_TRACK;
      w_misalign  = i_sof && (r_idx != '0) && (r_state == SYNC_TRACK);
    end
  end

  // Frame counter, first-sample tracker and sticky alignment flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= SYNC_FIRST;
      r_idx     <= '0;
      o_syncErr <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      if (w_misalign) begin
        o_syncErr <= 1'b1;
      end
    end
  end

  // Stage 1: capture the operand pair and the index it was tagged with
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Sof   <= 1'b0;
      r_s1Index <= '0;
      r_s1Dr    <= '0;
      r_s1Di    <= '0;
      r_s1Cr    <= '0;
      r_s1Ci    <= '0;
    end else begin
      r_s1Valid <= i_valid;
      r_s1Sof   <= i_valid && (w_tag == '0);
      r_s1Index <= w_tag;
      r_s1Dr    <= $signed(`CM_RE(i_data, DBITS));
      r_s1Di    <= $signed(`CM_IM(i_data, DBITS));
      r_s1Cr    <= $signed(`CM_RE(i_coeff, NBITS));
      r_s1Ci    <= $signed(`CM_IM(i_coeff, NBITS));
    end
  end

  // Stage 2: the four full-width signed partial products
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Sof   <= 1'b0;
      r_s2Index <= '0;
      r_s2Prr   <= '0;
      r_s2Pii   <= '0;
      r_s2Pri   <= '0;
      r_s2Pir   <= '0;
    end else begin
      r_s2Valid <= r_s1Valid;
      r_s2Sof   <= r_s1Sof;
      r_s2Index <= r_s1Index;
      r_s2Prr   <= PW'(r_s1Dr) * PW'(r_s1Cr);
      r_s2Pii   <= PW'(r_s1Di) * PW'(r_s1Ci);
      r_s2Pri   <= PW'(r_s1Dr) * PW'(r_s1Ci);
      r_s2Pir   <= PW'(r_s1Di) * PW'(r_s1Cr);
    end
  end

  // Complex sums, one extra bit wide so they never overflow
  always_comb begin
    w_sumRe = SW'(r_s2Prr) - SW'(r_s2Pii);
    w_sumIm = SW'(r_s2Pri) + SW'(r_s2Pir);
  end

  round_sat #(
    .IN_W (SW),
    .SHIFT(NBITS - 1),
    .OUT_W(DBITS),
    .RND  (roundConst(NBITS))
  ) u_roundRe (
    .i_val(w_sumRe),
    .o_val(w_outRe)
  );

  round_sat #(
    .IN_W (SW),
    .SHIFT(NBITS - 1),
    .OUT_W(DBITS),
    .RND  (roundConst(NBITS))
  ) u_roundIm (
    .i_val(w_sumIm),
    .o_val(w_outIm)
  );

  // Stage 3: output registers; data and index hold across idle cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_index <= '0;
      o_data  <= '0;
    end else begin
      o_valid <= r_s2Valid;
      o_sof   <= r_s2Valid && r_s2Sof;
      if (r_s2Valid) begin
        o_data  <= {w_outRe, w_outIm};
        o_index <= r_s2Index;
      end
    end
  end

endmodule

// File: tb/tb_coeff_mult.sv
// Self-checking bench for coeff_mult: directed arithmetic/framing/reset
// steps followed by random traffic, all compared against a plain
// arithmetic model of the complex multiply and frame counter.
module tb_coeff_mult;

  localparam int NB = 8;
  localparam int DB = 12;
  localparam int NN = 8;
  localparam int IW = 3;
  localparam int DEPTH = 1024;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2*NB-1:0] coeffIn;
  logic [2*DB-1:0] dataIn;
  logic            validIn;
  logic            sofIn;
  logic [2*DB-1:0] dataOut;
  logic            validOut;
  logic            sofOut;
  logic [IW-1:0]   indexOut;
  logic            syncErr;

  int checks = 0;
  int errors = 0;
  int edgeCnt = 0;

  bit          expValid [DEPTH];
  bit          expSof   [DEPTH];
  int          expIdx   [DEPTH];
  logic [23:0] expData  [DEPTH];

  logic [23:0] mLast;
  bit          mErr;
  bit          mFirst;
  int          mIdx;

  coeff_mult #(.NBITS(NB), .DBITS(DB), .N(NN)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_coeff  (coeffIn),
    .i_data   (dataIn),
    .i_valid  (validIn),
    .i_sof    (sofIn),
    .o_data   (dataOut),
    .o_valid  (validOut),
    .o_sof    (sofOut),
    .o_index  (indexOut),
    .o_syncErr(syncErr)
  );

  always #5 clk = ~clk;

  // Scale a Q1.7-weighted product back to a saturated 12-bit integer
  function automatic logic [11:0] scale(input longint s);
    longint r;
    r = (s + 64) >>> 7;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return 12'(r);
  endfunction

  task automatic checkBit(input string tag, input logic act, input logic exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, act, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, act, exp);
    end
  endtask

  // Compare every output against the model for the current edge
  task automatic checkOutput();
    bit v;
    v = expValid[edgeCnt];
    if (v) mLast = expData[edgeCnt];
    checkBit("out_valid", validOut, v);
    checkBit("out_sof", sofOut, v && expSof[edgeCnt]);
    checkWord("data_out", dataOut, mLast);
    checkBit("sync_err", syncErr, mErr);
    if (v) checkWord("out_index", 24'(indexOut), 24'(expIdx[edgeCnt]));
  endtask

  // Drive one cycle of input, advance one clock and update the model
  task automatic applyStimulus(input bit v, input bit s, input int cr, input int ci,
                               input int dr, input int di);
    int tag;
    longint pr;
    longint pim;
    validIn = v;
    sofIn   = s;
    coeffIn = {8'(cr), 8'(ci)};
    dataIn  = {12'(dr), 12'(di)};
    @(posedge clk);
    edgeCnt++;
    if (v && rst_n) begin
      if (s) begin
        if (!mFirst && mIdx != 0) mErr = 1'b1;
        tag = 0;
      end else begin
        tag = mIdx;
      end
      mIdx   = (tag + 1) % NN;
      mFirst = 1'b0;
      pr  = longint'(dr) * cr - longint'(di) * ci;
      pim = longint'(dr) * ci + longint'(di) * cr;
      expValid[edgeCnt + 2] = 1'b1;
      expSof[edgeCnt + 2]   = (tag == 0);
      expIdx[edgeCnt + 2]   = tag;
      expData[edgeCnt + 2]  = {scale(pr), scale(pim)};
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges, check outputs clear at once, hold two clocks
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkBit("rst_valid", validOut, 1'b0);
    checkBit("rst_sof", sofOut, 1'b0);
    checkBit("rst_err", syncErr, 1'b0);
    checkWord("rst_data", dataOut, 24'h0);
    checkWord("rst_index", 24'(indexOut), 24'h0);
    for (int i = edgeCnt + 1; i < DEPTH; i++) expValid[i] = 1'b0;
    mLast  = '0;
    mErr   = 1'b0;
    mFirst = 1'b1;
    mIdx   = 0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b1;
    coeffIn = '0;
    dataIn  = '0;
    validIn = 1'b0;
    sofIn   = 1'b0;
    #2;
    doReset();

    // Directed arithmetic cases, each drained to the output
    applyStimulus(1, 1, 64, 0, 100, -40);
    idle(2);
    checkWord("real_scale", dataOut, {12'(50), 12'(-20)});
    applyStimulus(1, 0, 0, 64, 100, 40);
    idle(2);
    checkWord("imag_rot", dataOut, {12'(-20), 12'(50)});
    applyStimulus(1, 0, 64, 0, 3, -3);
    idle(2);
    checkWord("rounding", dataOut, {12'(2), 12'(-1)});
    applyStimulus(1, 0, -128, -128, -2048, -2048);
    idle(2);
    checkWord("sat_im", dataOut, {12'(0), 12'(2047)});
    applyStimulus(1, 0, 127, 0, -2048, 0);
    idle(2);
    checkWord("neg_edge", dataOut, {12'(-2032), 12'(0)});

    // Reset with two samples in flight
    applyStimulus(1, 0, 50, -20, 300, 200);
    applyStimulus(1, 0, -70, 90, -500, 1000);
    doReset();
    idle(1);

    // Framing: marker only on beat 0, first beat after reset is exempt
    for (int b = 0; b < 20; b++) begin
      applyStimulus(1, b == 0, int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 4095)) - 2048,
                    int'($urandom_range(0, 4095)) - 2048);
      if (b == 0) checkBit("first_sof_exempt", syncErr, 1'b0);
    end
    idle(2);
    for (int b = 0; b < 7; b++) begin
      applyStimulus(1, 0, int'($urandom_range(0, 255)) - 128, 0,
                    int'($urandom_range(0, 4095)) - 2048, 0);
    end
    applyStimulus(1, 1, 64, 0, 10, 10);
    checkBit("misalign_set", syncErr, 1'b1);
    idle(2);
    checkWord("resync_index", 24'(indexOut), 24'h0);
    checkBit("resync_sof", sofOut, 1'b1);
    idle(2);
    checkBit("err_sticky", syncErr, 1'b1);

    // Random traffic with gaps and occasional frame markers
    for (int k = 0; k < 120; k++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(v, v && ($urandom_range(0, 9) == 0),
                    int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 4095)) - 2048,
                    int'($urandom_range(0, 4095)) - 2048);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coeff_mult.md
# coeff_mult

Consumer end of the twiddle-coefficient stream. It takes the free-running packed coefficient stream `{re, im}`, one coefficient per clock, and multiplies each coefficient by the matching complex data sample. It checks frame alignment against a start-of-frame marker, then rounds and saturates the product back to data width. It sits between the coefficient generator and the butterfly stage of each FFT lane.

## Interface
- `NBITS`, 8, width of each coefficient component; signed Q1.(NBITS-1)
- `DBITS`, 12, width of each data component; signed integer
- `N`, 8, coefficients per frame; index width `IW = clog2(N)`, minimum 1

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `coeff_in`  in  2*NBITS  coefficient, re in upper half, im in lower half
- `data_in`  in  2*DBITS  sample, re in upper half, im in lower half
- `in_valid`  in  1  `coeff_in`/`data_in` pair valid this cycle
- `in_sof`  in  1  pair is index 0 of a frame; qualified by `in_valid`
- `data_out`  out  2*DBITS  product, re in upper half, im in lower half
- `out_valid`  out  1  `data_out` valid
- `out_sof`  out  1  product is index 0
- `out_index`  out  IW  frame index of the product
- `sync_err`  out  1  sticky misalignment flag

## Operation
- Reset (`rst`=0) clears all pipeline registers, the index counter and `sync_err` immediately. Every output reads 0 during and after reset.
- **Product:**
  - `pr = dr*cr - di*ci`
  - `pi = dr*ci + di*cr`
  - Each partial product is DBITS+NBITS bits. Each sum is DBITS+NBITS+1 bits, signed throughout.
- **Scaling:**
  - Add `2^(NBITS-2)`, then arithmetic shift right by NBITS-1. This is round-half-up, so +1.5→2 and −1.5→−1.
  - Saturate to `[-2^(DBITS-1), 2^(DBITS-1)-1]`.
- **Index counter** (`idx`, IW bits): advances only on `in_valid`.
  - `in_valid & in_sof`: the sample is tagged index 0 and `idx` becomes 1 (mod N).
  - `in_valid & !in_sof`: the sample is tagged `idx` and `idx` becomes `(idx+1) mod N`, wrapping N-1→0.
  - `in_valid` low: `idx` holds.
- **Alignment check:** `in_valid & in_sof` while `idx != 0` sets `sync_err`.
  - Exempt: the first valid sample after reset.
  - The counter still resynchronises to 0 on that sample.
  - `sync_err` stays high until reset.
- **Unmarked frame start:** `in_sof` absent at wrap is legal. The counter free-runs and no error is raised.
- No backpressure. The downstream stage must accept every `out_valid` beat.

## Timing
- Fixed latency of 3 cycles, in-valid edge to out-valid edge. There are no bubbles and throughput is one sample per clock.
  - S1: register `data_in`, `coeff_in`, `in_sof` and the assigned index. Update the counter and `sync_err` here.
  - S2: the four signed products are registered.
  - S3: sums, rounding and saturation; results go to the output registers.
- `out_valid`, `out_sof` and `out_index` travel with their data through all 3 stages.
- Non-valid cycles propagate as `out_valid`=0. `data_out` holds its last value while `out_valid` is 0.
- `sync_err` rises on the cycle after the offending edge, i.e. 2 cycles before that sample's `out_valid`.
- Reset mid-stream: in-flight samples are discarded and no partial `out_valid` is produced. The first sample after release is treated as the exempt first sample.

## Structure
- Shared package / include header `coeff_mult_pkg`, holding:
  - the NBITS/DBITS defaults
  - the `clog2` function
  - the `re`/`im` half-slice macros, used by both the coefficient generator and this block
  - the round constant `2^(NBITS-2)`
- One sub-module, `round_sat`, parameterised on input width, shift and output width. It is instantiated twice in S3, once for re and once for im.
- Counter and alignment check stay in the top module.

## Test plan
All scenarios use NBITS=8, DBITS=12, N=8.

1. Real scaling: coeff (64,0), data (100,−40) → after 3 cycles `data_out`=(50,−20), `out_valid`=1.
2. Imaginary rotation: coeff (0,64), data (100,40) → (−20,50).
3. Rounding: coeff (64,0), data (3,−3) → (2,−1).
4. Saturation: coeff (−128,−128), data (−2048,−2048) → re 0, im clamps to 2047. With coeff (127,0), data (−2048,0) → re −2032.
5. Framing: 20 consecutive valids with `in_sof` only on beat 0 → `out_index` cycles 0..7,0..7,0..3 and `out_sof` is high on output beats 0, 8 and 16.
   - Then assert `in_sof` on a beat where idx=3 → `sync_err`=1 and stays 1, and that beat outputs `out_index`=0.
   - Gap `in_valid` for 2 cycles mid-frame → index holds, with no skipped index.
6. Reset: drop `rst` with 2 samples in flight → all outputs 0 immediately, and no `out_valid` after release until new input plus 3 cycles. `sync_err` is cleared, and an `in_sof` on the first post-reset valid does not set it.
